// File: rtl/ks_operand_gen.sv
// ks_operand_gen
//   Streams a reproducible set of operand pairs (op0, op1) into an adder under
//   test. Operands come from two seeded 32-bit Galois LFSRs (right shift, mask
//   32'h80200003); op0/op1 are the low WIDTH bits of LFSR0/LFSR1. A run of
//   num_vec pairs is launched by start and ends with a one-cycle done pulse.
//
//   Optional feature macro: CORNER_VEC_EN. When defined, every run begins
//   with four fixed corner pairs (0,0), (all1,all1), (all1,1),
//   (0xAAAA..,0x5555..) before the LFSR pairs; these count toward num_vec.
//
// Ports
//   clk          in   1        clock, rising edge
//   rst_n        in   1        asynchronous active-low reset
//   start        in   1        begin a run; sampled only in IDLE
//   num_vec      in   COUNT_W  pairs in the run; latched on accepted start
//   out_ready    in   1        consumer accepts the current pair
//   out_valid    out  1        op0/op1 hold a valid pair
//   op0          out  WIDTH    operand in0
//   op1          out  WIDTH    operand in1
//   vec_idx      out  COUNT_W  0-based index of the pair being presented
//   busy         out  1        high from accepted start until done
//   done         out  1        one-cycle pulse after the last transfer
//   dbg_state_o  out  2        current FSM state (IDLE=0, CORNER=1, RUN=2, DONE=3)
//
// Handshake: a transfer happens on a rising edge where out_valid & out_ready
// are both high. While out_valid is high and out_ready is low, op0, op1 and
// vec_idx are held bit-stable; out_valid never drops without a transfer.
// Pairs are presented back-to-back with no bubble while out_ready stays high.
module ks_operand_gen #(
  parameter int          WIDTH   = 32,
  parameter int          COUNT_W = 17,
  parameter logic [31:0] SEED0   = 32'h1,
  parameter logic [31:0] SEED1   = 32'hACE1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [COUNT_W-1:0] num_vec,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   op0,
  output logic [WIDTH-1:0]   op1,
  output logic [COUNT_W-1:0] vec_idx,
  output logic               busy,
  output logic               done,
  output logic [1:0]         dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CORNER = 2'd1,
    S_RUN    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // An all-zero seed would lock the LFSR at zero, so it is replaced by 1.
  localparam logic [31:0] SEED0_EFF = (SEED0 == 32'h0) ? 32'h1 : SEED0;
  localparam logic [31:0] SEED1_EFF = (SEED1 == 32'h0) ? 32'h1 : SEED1;
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    lfsr_step = s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

`ifdef CORNER_VEC_EN
  // Fixed corner pair k, returned as {op0, op1} truncated to WIDTH bits.
  function automatic logic [2*WIDTH-1:0] corner_pair(input logic [1:0] k);
    logic [31:0] a;
    logic [31:0] b;
    case (k)
      2'd0:    begin a = 32'h0000_0000; b = 32'h0000_0000; end
      2'd1:    begin a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
      2'd2:    begin a = 32'hFFFF_FFFF; b = 32'h0000_0001; end
      default: begin a = 32'hAAAA_AAAA; b = 32'h5555_5555; end
    endcase
    corner_pair = {WIDTH'(a), WIDTH'(b)};
  endfunction
`endif

  state_t             state_q, state_d;
  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   op0_q, op0_d;
  logic [WIDTH-1:0]   op1_q, op1_d;
  logic [COUNT_W-1:0] idx_q, idx_d;
  logic [COUNT_W-1:0] num_q, num_d;
  logic [31:0]        s0_q, s0_d;
  logic [31:0]        s1_q, s1_d;
  logic               busy_q, busy_d;

  logic               xfer;
  logic               last;
  logic [31:0]        s0_nx;
  logic [31:0]        s1_nx;

  assign xfer  = valid_q & out_ready;
  assign last  = (idx_q == (num_q - COUNT_W'(1)));
  assign s0_nx = lfsr_step(s0_q);
  assign s1_nx = lfsr_step(s1_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      op0_q   <= '0;
      op1_q   <= '0;
      idx_q   <= '0;
      num_q   <= '0;
      s0_q    <= SEED0_EFF;
      s1_q    <= SEED1_EFF;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      op0_q   <= op0_d;
      op1_q   <= op1_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      busy_q  <= busy_d;
    end
  end

  // s0_q/s1_q always hold the LFSR value whose low bits are being presented
  // in RUN; they advance only on a transfer that moves to the next pair.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    op0_d   = op0_q;
    op1_d   = op1_q;
    idx_d   = idx_q;
    num_d   = num_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    busy_d  = busy_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_vec != '0) begin
            num_d   = num_vec;
            s0_d    = SEED0_EFF;
            s1_d    = SEED1_EFF;
            idx_d   = '0;
            busy_d  = 1'b1;
            valid_d = 1'b1;
`ifdef CORNER_VEC_EN
            state_d        = S_CORNER;
            {op0_d, op1_d} = corner_pair(2'd0);
`else
            state_d = S_RUN;
            op0_d   = WIDTH'(SEED0_EFF);
            op1_d   = WIDTH'(SEED1_EFF);
`endif
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_CORNER: begin
`ifdef CORNER_VEC_EN
        if (xfer) begin
          if (last) begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + COUNT_W'(1);
            if (idx_q == COUNT_W'(3)) begin
              // LFSRs were not stepped during the corners: first pair = seeds.
              state_d = S_RUN;
              op0_d   = WIDTH'(s0_q);
              op1_d   = WIDTH'(s1_q);
            end else begin
              {op0_d, op1_d} = corner_pair(idx_q[1:0] + 2'd1);
            end
          end
        end
`else
        state_d = S_IDLE;
`endif
      end

      S_RUN: begin
        if (xfer) begin
          if (last) begin
            // vec_idx stays at num_vec-1; it never wraps.
            valid_d = 1'b0;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + COUNT_W'(1);
            s0_d  = s0_nx;
            s1_d  = s1_nx;
            op0_d = WIDTH'(s0_nx);
            op1_d = WIDTH'(s1_nx);
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign out_valid   = valid_q;
  assign op0         = op0_q;
  assign op1         = op1_q;
  assign vec_idx     = idx_q;
  assign busy        = busy_q;
  assign done        = (state_q == S_DONE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ks_operand_gen.sv
// tb_ks_operand_gen
//   Directed bench for ks_operand_gen (WIDTH=32, COUNT_W=17, default seeds).
//   Inputs are driven and outputs sampled on the falling clock edge. Expected
//   operand pairs come from a scoreboard queue filled by a small LFSR model
//   (and hand-computed constants for the first run).
module tb_ks_operand_gen;
  localparam int W  = 32;
  localparam int CW = 17;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] num_vec = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [W-1:0]  op0;
  logic [W-1:0]  op1;
  logic [CW-1:0] vec_idx;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  logic [2*W-1:0] exp_q[$];
  int             n_pass  = 0;
  int             n_total = 0;
  int             exp_idx = 0;
  logic [31:0]    m1;

  ks_operand_gen #(
    .WIDTH  (W),
    .COUNT_W(CW),
    .SEED0  (32'h1),
    .SEED1  (32'hACE1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_vec    (num_vec),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .op0        (op0),
    .op1        (op1),
    .vec_idx    (vec_idx),
    .busy       (busy),
    .done       (done),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] m_step(input logic [31:0] s);
    if (s[0]) return (s >> 1) ^ 32'h8020_0003;
    else      return s >> 1;
  endfunction

  // Fill the scoreboard with the n pairs a run from the default seeds produces.
  task automatic load_exp(input int n);
    logic [31:0] s0;
    logic [31:0] s1;
    s0 = 32'h1;
    s1 = 32'hACE1;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
`ifdef CORNER_VEC_EN
      if      (i == 0) exp_q.push_back({32'h0000_0000, 32'h0000_0000});
      else if (i == 1) exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFF});
      else if (i == 2) exp_q.push_back({32'hFFFF_FFFF, 32'h0000_0001});
      else if (i == 3) exp_q.push_back({32'hAAAA_AAAA, 32'h5555_5555});
      else begin
        exp_q.push_back({s0, s1});
        s0 = m_step(s0);
        s1 = m_step(s1);
      end
`else
      exp_q.push_back({s0, s1});
      s0 = m_step(s0);
      s1 = m_step(s1);
`endif
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called on a falling edge; leaves the bench on the falling edge after the
  // start was sampled.
  task automatic do_start(input string tag, input int nv);
    start   = 1'b1;
    num_vec = CW'(nv);
    @(negedge clk);
    start   = 1'b0;
    num_vec = CW'($urandom_range(0, 50));
    if (nv != 0) begin
      check({tag, " valid after start"}, out_valid, 1);
      check({tag, " busy after start"}, busy, 1);
      check({tag, " idx after start"}, vec_idx, 0);
      check({tag, " no done while busy"}, done, 0);
    end
  endtask

  // Consume a run, comparing every transfer against the scoreboard, checking
  // stall stability, and checking the done pulse. poke raises start (with a
  // different num_vec) mid-run, which must have no effect.
  task automatic run_stream(input string tag, input int n_exp, input bit toggle, input bit poke);
    int            cyc;
    int            got;
    int            last_x;
    bit            stalled;
    bit            seen;
    logic [W-1:0]  h0;
    logic [W-1:0]  h1;
    logic [CW-1:0] hi;
    logic [63:0]   e;
    cyc = 0; got = 0; last_x = -10; seen = 0; exp_idx = 0;
    while (!seen && cyc < 200) begin
      out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      start     = poke && (cyc == 1);
      if (poke && cyc == 1) num_vec = CW'(1);
      stalled = out_valid && !out_ready;
      h0 = op0; h1 = op1; hi = vec_idx;
      if (out_valid && out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        check({tag, " pair"}, {op0, op1}, e);
        check({tag, " vec_idx"}, vec_idx, exp_idx);
        exp_idx++;
        got++;
        last_x = cyc;
      end
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (stalled) begin
        check({tag, " stall op0"}, op0, h0);
        check({tag, " stall op1"}, op1, h1);
        check({tag, " stall idx"}, vec_idx, hi);
        check({tag, " stall valid"}, out_valid, 1);
      end
      if (done) seen = 1;
    end
    check({tag, " done seen"}, seen, 1);
    check({tag, " transfers"}, got, n_exp);
    check({tag, " done latency"}, cyc - last_x, 1);
    check({tag, " busy in done"}, busy, 0);
    check({tag, " valid in done"}, out_valid, 0);
    @(negedge clk);
    check({tag, " done one cycle"}, done, 0);
    check({tag, " busy after done"}, busy, 0);
    out_ready = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset valid", out_valid, 0);
    check("reset op0", op0, 0);
    check("reset op1", op1, 0);
    check("reset idx", vec_idx, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: three pairs, out_ready held high.
`ifdef CORNER_VEC_EN
    load_exp(3);
`else
    exp_q.delete();
    m1 = 32'hACE1;
    exp_q.push_back({32'h0000_0001, m1});
    m1 = m_step(m1);
    exp_q.push_back({32'h8020_0003, m1});
    m1 = m_step(m1);
    exp_q.push_back({32'hC030_0002, m1});
`endif
    do_start("t1", 3);
    run_stream("t1", 3, 1'b0, 1'b0);

    // 2: five pairs with out_ready toggling every cycle.
    load_exp(5);
    do_start("t2", 5);
    run_stream("t2", 5, 1'b1, 1'b0);

    // 3: zero-length run.
    out_ready = 1'b1;
    do_start("t3", 0);
    check("t3 done", done, 1);
    check("t3 busy in done", busy, 0);
    check("t3 valid", out_valid, 0);
    @(negedge clk);
    check("t3 done one cycle", done, 0);
    check("t3 busy after", busy, 0);
    check("t3 valid after", out_valid, 0);
    out_ready = 1'b0;

    // 4: same seeds again must reproduce the sequence.
    load_exp(8);
    do_start("t4", 8);
    run_stream("t4", 8, 1'b0, 1'b0);

    // 5: asynchronous reset in the middle of a 10-pair run.
    load_exp(10);
    do_start("t5", 10);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("t5 idx before reset", vec_idx, 2);
    #2 rst_n = 1'b0;
    #1;
    check("t5 async valid", out_valid, 0);
    check("t5 async op0", op0, 0);
    check("t5 async op1", op1, 0);
    check("t5 async idx", vec_idx, 0);
    check("t5 async busy", busy, 0);
    check("t5 async done", done, 0);
    @(negedge clk);
    check("t5 no done in reset", done, 0);
    rst_n = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    check("t5 no done after reset", done, 0);
    check("t5 idle valid", out_valid, 0);
    load_exp(4);
    do_start("t5r", 4);
    run_stream("t5r", 4, 1'b0, 1'b0);

    // 6: start raised while busy is ignored (corner pairs lead when enabled).
`ifdef CORNER_VEC_EN
    load_exp(6);
    do_start("t6", 6);
    run_stream("t6", 6, 1'b0, 1'b1);
`else
    load_exp(4);
    do_start("t6", 4);
    run_stream("t6", 4, 1'b0, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
